// File: rtl/tcp_pkg.sv
// tcp_pkg: definitions shared by the TCP receive and transmit paths.
//   - fixed header geometry (words / bytes)
//   - control-flag bit positions inside the 8-bit flags field
//   - receive status codes reported alongside pkt_done
//   - receive FSM state encoding
//   - hdr_words(): data-offset field -> effective header length in words
package tcp_pkg;

  localparam int TCP_HDR_WORDS = 5;
  localparam int TCP_HDR_BYTES = 20;

  // Bit positions inside flags (header word3[23:16]).
  localparam int FLAG_FIN = 0;
  localparam int FLAG_SYN = 1;
  localparam int FLAG_RST = 2;
  localparam int FLAG_PSH = 3;
  localparam int FLAG_ACK = 4;
  localparam int FLAG_URG = 5;

  typedef enum logic [1:0] {
    ERR_OK    = 2'd0,
    ERR_PORT  = 2'd1,
    ERR_LEN   = 2'd2,
    ERR_TRUNC = 2'd3
  } err_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_OPT,
    ST_PAYLOAD,
    ST_DROP
  } rx_state_t;

  // Offsets 0..5 all describe the minimal header; the transmit side sends
  // offset 4 on control segments, so anything below 5 is promoted to 5.
  function automatic logic [3:0] hdr_words(input logic [3:0] offset);
    return (offset < 4'(TCP_HDR_WORDS)) ? 4'(TCP_HDR_WORDS) : offset;
  endfunction

endpackage

// File: rtl/tcp_recv_be_gen.sv
// tcp_recv_be_gen: combinational byte-enable / last-word generator.
// Ports:
//   remaining  in  16  payload bytes still expected, including this word
//   be         out  4  byte enables, [3] = byte [31:24]
//   last       out  1  this word carries the final payload byte
module tcp_recv_be_gen
  import tcp_pkg::*;
(
  input  logic [15:0] remaining,
  output logic [3:0]  be,
  output logic        last
);

  always_comb begin
    be   = 4'b1111;
    last = (remaining <= 16'd4);
    // Bytes are packed from the MSB, so a short final word keeps its top lanes.
    case (remaining)
      16'd1:   be = 4'b1000;
      16'd2:   be = 4'b1100;
      16'd3:   be = 4'b1110;
      default: be = 4'b1111;
    endcase
  end

endmodule

// File: rtl/tcp_recv.sv
// tcp_recv: TCP segment receiver. Parses a 32-bit big-endian word stream
// (header + options + payload), filters on destination port and streams the
// payload out with byte enables and a last marker.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   tcp_data_in / tcp_data_valid_in   segment words; valid low ends a segment
//   tcp_length_in, ip_addr_in         segment length and source IP, taken with word 0
//   ip_addr_out, src_port_out, dst_port_out, seq_out, ack_out, flags_out,
//   win_out                           header fields, held until the next word 0
//   hdr_valid, payload_len_out        1-cycle pulse when the header is accepted
//   data_out, data_out_valid, data_out_be, data_out_last   payload stream
//   pkt_done, err_status              1-cycle pulse at segment end + status
module tcp_recv
  import tcp_pkg::*;
#(
  parameter logic [15:0] LOCAL_PORT = 16'h0400,
  parameter bit          CHECK_PORT = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] tcp_data_in,
  input  logic        tcp_data_valid_in,
  input  logic [15:0] tcp_length_in,
  input  logic [31:0] ip_addr_in,
  output logic [31:0] ip_addr_out,
  output logic [15:0] src_port_out,
  output logic [15:0] dst_port_out,
  output logic [31:0] seq_out,
  output logic [31:0] ack_out,
  output logic [7:0]  flags_out,
  output logic [15:0] win_out,
  output logic        hdr_valid,
  output logic [31:0] data_out,
  output logic        data_out_valid,
  output logic [3:0]  data_out_be,
  output logic        data_out_last,
  output logic [15:0] payload_len_out,
  output logic        pkt_done,
  output logic [1:0]  err_status
);

  rx_state_t   state;
  logic [2:0]  word_cnt;   // header word index while in ST_HDR
  logic [3:0]  opt_cnt;    // option words still to skip
  logic [3:0]  offset;     // raw data-offset field from word 3
  logic [15:0] seg_len;    // tcp_length_in latched with word 0
  logic [15:0] remaining;  // payload bytes not yet emitted
  err_t        status;     // outcome reported if the segment ends in ST_DROP

  logic [3:0]  hl;
  logic [15:0] hdr_bytes;
  logic [15:0] pay_len;
  logic        len_bad;
  logic        port_bad;
  logic        hdr_last;
  logic [3:0]  be_next;
  logic        last_next;

  tcp_recv_be_gen u_be_gen (
    .remaining (remaining),
    .be        (be_next),
    .last      (last_next)
  );

  assign hl        = hdr_words(offset);
  assign hdr_bytes = {10'd0, hl, 2'b00};
  assign len_bad   = (seg_len < hdr_bytes);
  assign port_bad  = CHECK_PORT && (dst_port_out != LOCAL_PORT);
  assign pay_len   = seg_len - hdr_bytes;

  // The cycle whose word completes the header (fixed part plus options).
  // offset was captured from word 3 one cycle before word 4 arrives.
  assign hdr_last = tcp_data_valid_in &&
                    (((state == ST_HDR) && (word_cnt == 3'd4) && (hl == 4'd5)) ||
                     ((state == ST_OPT) && (opt_cnt == 4'd1)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      word_cnt        <= '0;
      opt_cnt         <= '0;
      offset          <= '0;
      seg_len         <= '0;
      remaining       <= '0;
      status          <= ERR_OK;
      ip_addr_out     <= '0;
      src_port_out    <= '0;
      dst_port_out    <= '0;
      seq_out         <= '0;
      ack_out         <= '0;
      flags_out       <= '0;
      win_out         <= '0;
      hdr_valid       <= 1'b0;
      data_out        <= '0;
      data_out_valid  <= 1'b0;
      data_out_be     <= '0;
      data_out_last   <= 1'b0;
      payload_len_out <= '0;
      pkt_done        <= 1'b0;
      err_status      <= '0;
    end else begin
      hdr_valid      <= 1'b0;
      pkt_done       <= 1'b0;
      data_out_valid <= 1'b0;
      data_out_last  <= 1'b0;

      if ((state != ST_IDLE) && !tcp_data_valid_in) begin
        // Segment end. Only ST_DROP means every expected word arrived;
        // anywhere else the stream stopped early.
        pkt_done   <= 1'b1;
        err_status <= (state == ST_DROP) ? status : ERR_TRUNC;
        state      <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (tcp_data_valid_in) begin
              src_port_out <= tcp_data_in[31:16];
              dst_port_out <= tcp_data_in[15:0];
              ip_addr_out  <= ip_addr_in;
              seg_len      <= tcp_length_in;
              word_cnt     <= 3'd1;
              status       <= ERR_OK;
              state        <= ST_HDR;
            end
          end
          ST_HDR: begin
            case (word_cnt)
              3'd1: seq_out <= tcp_data_in;
              3'd2: ack_out <= tcp_data_in;
              3'd3: begin
                offset    <= tcp_data_in[31:28];
                flags_out <= tcp_data_in[23:16];
                win_out   <= tcp_data_in[15:0];
              end
              default: ;  // word 4: checksum / urgent pointer, not used
            endcase
            word_cnt <= word_cnt + 3'd1;
            if ((word_cnt == 3'd4) && (hl > 4'd5)) begin
              opt_cnt <= hl - 4'd5;
              state   <= ST_OPT;
            end
          end
          ST_OPT: begin
            opt_cnt <= opt_cnt - 4'd1;
          end
          ST_PAYLOAD: begin
            data_out       <= tcp_data_in;
            data_out_be    <= be_next;
            data_out_last  <= last_next;
            data_out_valid <= 1'b1;
            remaining      <= remaining - 16'd4;
            // Anything after the final word is surplus and silently absorbed.
            if (last_next) begin
              state <= ST_DROP;
            end
          end
          ST_DROP: ;
          default: state <= ST_IDLE;
        endcase

        // Header complete: decide the fate of the segment. Overrides any
        // state change made above in the same cycle.
        if (hdr_last) begin
          if (len_bad) begin
            status <= ERR_LEN;
            state  <= ST_DROP;
          end else if (port_bad) begin
            status <= ERR_PORT;
            state  <= ST_DROP;
          end else begin
            hdr_valid       <= 1'b1;
            payload_len_out <= pay_len;
            remaining       <= pay_len;
            // Zero-length payload: nothing to stream, wait for valid to fall.
            state           <= (pay_len == 16'd0) ? ST_DROP : ST_PAYLOAD;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tcp_recv.sv
// tb_tcp_recv: directed and random segments driven into tcp_recv. A
// segment-level reference model predicts, per segment, the header record,
// the payload words and the completion status together with the cycle on
// which each must appear; a negedge monitor records what the DUT produced.
module tb_tcp_recv;

  localparam logic [15:0] LOCAL = 16'h0400;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] tcp_data_in;
  logic        tcp_data_valid_in;
  logic [15:0] tcp_length_in;
  logic [31:0] ip_addr_in;
  logic [31:0] ip_addr_out;
  logic [15:0] src_port_out;
  logic [15:0] dst_port_out;
  logic [31:0] seq_out;
  logic [31:0] ack_out;
  logic [7:0]  flags_out;
  logic [15:0] win_out;
  logic        hdr_valid;
  logic [31:0] data_out;
  logic        data_out_valid;
  logic [3:0]  data_out_be;
  logic        data_out_last;
  logic [15:0] payload_len_out;
  logic        pkt_done;
  logic [1:0]  err_status;

  always #5 clk = ~clk;

  tcp_recv #(.LOCAL_PORT(LOCAL), .CHECK_PORT(1'b1)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .tcp_data_in       (tcp_data_in),
    .tcp_data_valid_in (tcp_data_valid_in),
    .tcp_length_in     (tcp_length_in),
    .ip_addr_in        (ip_addr_in),
    .ip_addr_out       (ip_addr_out),
    .src_port_out      (src_port_out),
    .dst_port_out      (dst_port_out),
    .seq_out           (seq_out),
    .ack_out           (ack_out),
    .flags_out         (flags_out),
    .win_out           (win_out),
    .hdr_valid         (hdr_valid),
    .data_out          (data_out),
    .data_out_valid    (data_out_valid),
    .data_out_be       (data_out_be),
    .data_out_last     (data_out_last),
    .payload_len_out   (payload_len_out),
    .pkt_done          (pkt_done),
    .err_status        (err_status)
  );

  typedef struct packed { int cyc; logic [167:0] f; } hdr_rec_t;
  typedef struct packed { int cyc; logic [36:0]  f; } dat_rec_t;
  typedef struct packed { int cyc; logic [1:0]   st; } done_rec_t;

  hdr_rec_t  obs_hdr[$],  exp_hdr[$];
  dat_rec_t  obs_dat[$],  exp_dat[$];
  done_rec_t obs_done[$], exp_done[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: one record per output event, stamped with the cycle number.
  hdr_rec_t  mon_h;
  dat_rec_t  mon_d;
  done_rec_t mon_p;
  always @(negedge clk) begin
    if (hdr_valid) begin
      mon_h.cyc = cyc;
      mon_h.f   = {ip_addr_out, src_port_out, dst_port_out, seq_out, ack_out,
                   flags_out, win_out, payload_len_out};
      obs_hdr.push_back(mon_h);
    end
    if (data_out_valid) begin
      mon_d.cyc = cyc;
      mon_d.f   = {data_out, data_out_be, data_out_last};
      obs_dat.push_back(mon_d);
    end
    if (pkt_done) begin
      mon_p.cyc = cyc;
      mon_p.st  = err_status;
      obs_done.push_back(mon_p);
    end
  end

  int total  = 0;
  int passes = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Current segment: words, length and source IP presented with word 0.
  logic [31:0] seg[$];
  logic [15:0] seg_len;
  logic [31:0] seg_ip;

  // Reference model. Word i is sampled on the (i+1)-th edge after base, so
  // the header appears hl cycles after base, payload word j one cycle after
  // it is sampled, and pkt_done one cycle after valid is seen low.
  task automatic model_seg(input int base);
    int n, hl, plen, nw, avail, rem, k;
    logic [1:0] st;
    logic [3:0] be;
    hdr_rec_t h;
    dat_rec_t d;
    done_rec_t dn;
    n  = seg.size();
    st = 2'd3;
    if (n >= 5) begin
      hl = (seg[3][31:28] < 4'd5) ? 5 : int'(seg[3][31:28]);
      if (n >= hl) begin
        if (int'(seg_len) < 4 * hl) st = 2'd2;
        else if (seg[0][15:0] != LOCAL) st = 2'd1;
        else begin
          plen  = int'(seg_len) - 4 * hl;
          h.cyc = base + hl;
          h.f   = {seg_ip, seg[0], seg[1], seg[2], seg[3][23:0], 16'(plen)};
          exp_hdr.push_back(h);
          nw    = (plen + 3) / 4;
          avail = n - hl;
          for (int j = 0; j < nw && j < avail; j++) begin
            rem   = plen - 4 * j;
            k     = (rem < 4) ? rem : 4;
            be    = 4'b1111 << (4 - k);
            d.cyc = base + hl + j + 1;
            d.f   = {seg[hl + j], be, (rem <= 4)};
            exp_dat.push_back(d);
          end
          st = (avail < nw) ? 2'd3 : 2'd0;
        end
      end
    end
    dn.cyc = base + n + 1;
    dn.st  = st;
    exp_done.push_back(dn);
  endtask

  task automatic drive_word(input int i);
    tcp_data_valid_in = 1'b1;
    tcp_data_in       = seg[i];
    tcp_length_in     = (i == 0) ? seg_len : 16'($urandom);
    ip_addr_in        = (i == 0) ? seg_ip : $urandom;
  endtask

  // Called at a drive point (#1 after a rising edge). gap = idle cycles
  // before the next drive point; gap 1 puts the next word 0 on pkt_done.
  task automatic send_seg(input int gap);
    model_seg(cyc);
    for (int i = 0; i < seg.size(); i++) begin
      drive_word(i);
      @(posedge clk); #1;
    end
    tcp_data_valid_in = 1'b0;
    tcp_data_in       = $urandom;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic compare_all();
    int m;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("hdr_count", obs_hdr.size(), exp_hdr.size());
    m = (obs_hdr.size() < exp_hdr.size()) ? obs_hdr.size() : exp_hdr.size();
    for (int i = 0; i < m; i++) begin
      chk("hdr_cycle", obs_hdr[i].cyc, exp_hdr[i].cyc);
      chk("hdr_fields", obs_hdr[i].f, exp_hdr[i].f);
    end
    chk("data_count", obs_dat.size(), exp_dat.size());
    m = (obs_dat.size() < exp_dat.size()) ? obs_dat.size() : exp_dat.size();
    for (int i = 0; i < m; i++) begin
      chk("data_cycle", obs_dat[i].cyc, exp_dat[i].cyc);
      chk("data_word_be_last", obs_dat[i].f, exp_dat[i].f);
    end
    chk("done_count", obs_done.size(), exp_done.size());
    m = (obs_done.size() < exp_done.size()) ? obs_done.size() : exp_done.size();
    for (int i = 0; i < m; i++) begin
      chk("done_cycle", obs_done[i].cyc, exp_done[i].cyc);
      chk("done_status", obs_done[i].st, exp_done[i].st);
    end
    obs_hdr.delete();  exp_hdr.delete();
    obs_dat.delete();  exp_dat.delete();
    obs_done.delete(); exp_done.delete();
    @(posedge clk); #1;
  endtask

  task automatic gen_random();
    logic [3:0]  off;
    logic [15:0] dst;
    int hl, plen, nfull, n;
    dst   = ($urandom_range(0, 4) == 0) ? 16'($urandom) : LOCAL;
    off   = 4'($urandom_range(0, 9));
    hl    = (off < 4'd5) ? 5 : int'(off);
    plen  = $urandom_range(0, 17);
    seg_len = 16'(4 * hl + plen);
    if ($urandom_range(0, 7) == 0) seg_len = 16'($urandom_range(0, 4 * hl - 1));
    nfull = hl + (plen + 3) / 4;
    n     = nfull + (($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
    if ($urandom_range(0, 5) == 0) n = $urandom_range(1, nfull - 1);
    seg.delete();
    for (int i = 0; i < n; i++) begin
      if (i == 0)      seg.push_back({16'($urandom), dst});
      else if (i == 3) seg.push_back({off, 4'($urandom), 8'($urandom), 16'($urandom)});
      else             seg.push_back($urandom);
    end
    seg_ip = $urandom;
  endtask

  logic [209:0] all_out;
  assign all_out = {ip_addr_out, src_port_out, dst_port_out, seq_out, ack_out,
                    flags_out, win_out, hdr_valid, data_out, data_out_valid,
                    data_out_be, data_out_last, payload_len_out, pkt_done, err_status};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n           = 1'b0;
    tcp_data_in       = '0;
    tcp_data_valid_in = 1'b0;
    tcp_length_in     = '0;
    ip_addr_in        = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", all_out, '0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Data segment, 8-byte payload.
    seg = '{32'h04000400, 32'h55bc55bc, 32'hbc55bc55, 32'h50000008,
            32'h00000000, 32'hDEADBEEF, 32'h12345678};
    seg_len = 16'd28; seg_ip = 32'hC0A80001;
    send_seg(2);
    // Control segment with offset 4 (SYN), no payload.
    seg = '{32'h12340400, 32'h00000001, 32'h00000002, 32'h40020400, 32'h0};
    seg_len = 16'd20; seg_ip = 32'h0A000002;
    send_seg(2);
    // Odd lengths: 3-byte and 7-byte payloads.
    seg = '{32'h00500400, 32'h11, 32'h22, 32'h50180100, 32'h0, 32'hA1B2C3D4};
    seg_len = 16'd23; seg_ip = 32'h0A000003;
    send_seg(2);
    seg = '{32'h00500400, 32'h11, 32'h22, 32'h50180100, 32'h0, 32'hCAFEF00D, 32'h0BADBEEF};
    seg_len = 16'd27; seg_ip = 32'h0A000004;
    send_seg(2);
    // Options: 7-word header, payload starts at the 8th word.
    seg = '{32'h04000400, 32'h33, 32'h44, 32'h70100400, 32'h0,
            32'h01010101, 32'h02020202, 32'h600DF00D, 32'hFEEDFACE};
    seg_len = 16'd36; seg_ip = 32'h0A000005;
    send_seg(2);
    // Destination port mismatch.
    seg = '{32'h12340401, 32'h1, 32'h2, 32'h50100400, 32'h0, 32'h99999999};
    seg_len = 16'd24; seg_ip = 32'h0A000006;
    send_seg(2);
    // Truncated after three words.
    seg = '{32'h04000400, 32'h1, 32'h2};
    seg_len = 16'd28; seg_ip = 32'h0A000007;
    send_seg(2);
    // Back-to-back: next word 0 in the pkt_done cycle.
    seg = '{32'h12340400, 32'h5, 32'h6, 32'h40110400, 32'h0};
    seg_len = 16'd20; seg_ip = 32'h0A000008;
    send_seg(1);
    seg = '{32'h04000400, 32'h7, 32'h8, 32'h50180400, 32'h0, 32'h13579BDF};
    seg_len = 16'd22; seg_ip = 32'h0A000009;
    send_seg(2);
    compare_all();

    // Reset in the middle of a payload.
    seg = '{32'h04000400, 32'h55bc55bc, 32'hbc55bc55, 32'h50000008,
            32'h00000000, 32'hDEADBEEF, 32'h12345678};
    seg_len = 16'd28; seg_ip = 32'hC0A80001;
    for (int i = 0; i < 6; i++) begin
      drive_word(i);
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    #1;
    chk("reset_mid_outputs", all_out, '0);
    @(posedge clk); @(posedge clk); #1;
    chk("reset_held_outputs", all_out, '0);
    tcp_data_valid_in = 1'b0;
    reset_n = 1'b1;
    obs_hdr.delete(); obs_dat.delete(); obs_done.delete();
    @(posedge clk); #1;
    send_seg(2);
    compare_all();

    // Random segments.
    for (int s = 0; s < 48; s++) begin
      gen_random();
      send_seg($urandom_range(1, 3));
      if ((s % 8) == 7) compare_all();
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
